// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer that issues operands to an external ALU,
// optionally performs a req/ack memory transaction, and writes results back
// into an internal 8-entry register file (R0 hard-wired to zero).
module alu_sequencer #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  output logic [2:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic [2:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_LOAD = 3'b100;
  localparam logic [2:0] OP_STR  = 3'b101;

  localparam int unsigned       CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_e;

  state_e                  state_q, state_d;
  logic [11:0]             instr_q, instr_d;
  logic [2:0]              opc_q, opc_d;
  logic [WIDTH-1:0]        a_q, a_d;
  logic [WIDTH-1:0]        b_q, b_d;
  logic                    we_q, we_d;
  logic [WIDTH-1:0]        addr_q, addr_d;
  logic [WIDTH-1:0]        wdata_q, wdata_d;
  logic [WIDTH-1:0]        wb_data_q, wb_data_d;
  logic [CNT_W-1:0]        tmo_q, tmo_d;
  logic                    err_q, err_d;
  logic [7:0][WIDTH-1:0]   regs_q, regs_d;

  // Instruction fields; the low nibble of instr carries nothing.
  logic [2:0] f_op, f_rd, f_rs1, f_rs2;
  logic       instr_unused;
  assign f_op         = instr_q[11:9];
  assign f_rd         = instr_q[8:6];
  assign f_rs1        = instr_q[5:3];
  assign f_rs2        = instr_q[2:0];
  assign instr_unused = ^instr[3:0];

  // State register and datapath latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      opc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wb_data_q <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      regs_q    <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      opc_q     <= opc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wb_data_q <= wb_data_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      regs_q    <= regs_d;
    end
  end

  // Next-state and datapath update. err is registered so its pulse lands in
  // the first IDLE cycle after an abort and can never overlap done (WB only).
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    opc_d     = opc_q;
    a_d       = a_q;
    b_d       = b_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wb_data_d = wb_data_q;
    tmo_d     = tmo_q;
    err_d     = 1'b0;
    regs_d    = regs_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instr[15:4];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        opc_d   = f_op;
        a_d     = regs_q[f_rs1];
        b_d     = regs_q[f_rs2];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (opc_q)
          OP_ADD, OP_SUB: begin
            wb_data_d = alu_result;
            state_d   = S_WB;
          end
          OP_LOAD, OP_STR: begin
            addr_d  = alu_result;
            we_d    = (opc_q == OP_STR);
            wdata_d = (opc_q == OP_STR) ? regs_q[f_rd] : '0;
            tmo_d   = '0;
            state_d = S_MEM;
          end
          default: begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        endcase
      end
      S_MEM: begin
        if (mem_ack) begin
          if (!we_q) begin
            wb_data_d = mem_rdata;
          end
          state_d = S_WB;
        end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WB: begin
        if ((opc_q != OP_STR) && (f_rd != 3'd0)) begin
          regs_d[f_rd] = wb_data_q;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state and latched datapath registers.
  always_comb begin
    instr_ready = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    mem_req     = (state_q == S_MEM);
    done        = (state_q == S_WB);
    err         = err_q;
    alu_opcode  = opc_q;
    alu_a       = a_q;
    alu_b       = b_q;
    mem_we      = we_q;
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
    dbg_data    = regs_q[dbg_sel];
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: two instances (default timeout and
// TIMEOUT=4) share stimulus; a behavioural ALU and memory responder close the loop.
module tb_alu_sequencer;
  localparam int W = 16;
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_LOAD = 3'b100;
  localparam logic [2:0] OP_STR  = 3'b101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic [2:0] dbg_sel = '0;
  logic mem_ack = 1'b0;
  logic [W-1:0] mem_rdata = '0;

  logic ready0, req0, we0, busy0, done0, err0;
  logic [2:0] opc0;
  logic [W-1:0] a0, b0, res0, addr0, wdata0, dbg0;
  logic ready4, req4, we4, busy4, done4, err4;
  logic [2:0] opc4;
  logic [W-1:0] a4, b4, res4, addr4, wdata4, dbg4;

  always #5 clk = ~clk;

  // External ALU model
  always_comb res0 = (opc0 == OP_SUB) ? a0 - b0 : a0 + b0;
  always_comb res4 = (opc4 == OP_SUB) ? a4 - b4 : a4 + b4;

  alu_sequencer #(.WIDTH(W), .TIMEOUT(255)) u_dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(ready0), .alu_opcode(opc0), .alu_a(a0), .alu_b(b0),
    .alu_result(res0), .mem_req(req0), .mem_we(we0), .mem_addr(addr0),
    .mem_wdata(wdata0), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy0), .done(done0), .err(err0), .dbg_sel(dbg_sel), .dbg_data(dbg0)
  );

  alu_sequencer #(.WIDTH(W), .TIMEOUT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(ready4), .alu_opcode(opc4), .alu_a(a4), .alu_b(b4),
    .alu_result(res4), .mem_req(req4), .mem_we(we4), .mem_addr(addr4),
    .mem_wdata(wdata4), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy4), .done(done4), .err(err4), .dbg_sel(dbg_sel), .dbg_data(dbg4)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 4'b0000};
  endfunction

  typedef struct { bit is_err; int at; } ev_t;
  typedef struct { bit we; logic [15:0] addr; logic [15:0] wdata; int cycles; } mx_t;
  ev_t evq0[$];
  ev_t evq4[$];
  mx_t mq0[$];
  int  mq4[$];

  // Memory responder: ack after ack_delay request cycles (-1 = never)
  int ack_delay = -1;
  logic [15:0] rdata_val = '0;
  int rcnt = 0;
  always @(negedge clk) begin
    if (req0) begin
      mem_ack = (rcnt == ack_delay);
      mem_rdata = rdata_val;
      rcnt++;
    end else begin
      mem_ack = 1'b0;
      rcnt = 0;
    end
  end

  // Completion monitor, default-timeout instance
  ev_t e0;
  bit chk_ready0 = 0;
  always @(negedge clk) begin
    if (chk_ready0) begin
      check("ready_after_wb0", ready0, 1);
      chk_ready0 = 0;
    end
    if (done0 || err0) begin
      check("done_and_err0", done0 & err0, 0);
      if (evq0.size() == 0) check("unexpected_event0", {done0, err0}, 0);
      else begin
        e0 = evq0.pop_front();
        check("event_kind0", err0, e0.is_err);
        if (e0.at >= 0) check("event_cycle0", cyc, e0.at);
        if (done0) begin
          check("ready_in_wb0", ready0, 0);
          chk_ready0 = 1;
        end
      end
    end
  end

  // Memory-transaction monitor, default-timeout instance
  bit in0 = 0;
  bit unstable0 = 0;
  int rc0 = 0;
  mx_t cur0;
  always @(negedge clk) begin
    if (req0) begin
      if (!in0) begin
        in0 = 1; rc0 = 0; unstable0 = 0;
        if (mq0.size() == 0) check("unexpected_req0", req0, 0);
        else begin
          cur0 = mq0.pop_front();
          check("mem_we0", we0, cur0.we);
          check("mem_addr0", addr0, cur0.addr);
          if (cur0.we) check("mem_wdata0", wdata0, cur0.wdata);
        end
      end
      rc0++;
      if (we0 !== cur0.we || addr0 !== cur0.addr || (cur0.we && wdata0 !== cur0.wdata))
        unstable0 = 1;
    end else if (in0) begin
      in0 = 0;
      check("mem_stable0", unstable0, 0);
      if (cur0.cycles >= 0) check("req_cycles0", rc0, cur0.cycles);
    end
  end

  // Completion and request-length monitor, TIMEOUT=4 instance
  ev_t e4;
  int rq4 = 0;
  always @(negedge clk) begin
    if (done4 || err4) begin
      if (evq4.size() == 0) check("unexpected_event4", {done4, err4}, 0);
      else begin
        e4 = evq4.pop_front();
        check("event_kind4", err4, e4.is_err);
        if (e4.at >= 0) check("event_cycle4", cyc, e4.at);
      end
    end
    if (req4) rq4++;
    else if (rq4 != 0) begin
      if (mq4.size() == 0) check("unexpected_req4", rq4, 0);
      else check("req_cycles4", rq4, mq4.pop_front());
      rq4 = 0;
    end
  end

  task automatic push_mem(input bit we, input logic [15:0] addr, input logic [15:0] wd,
                          input int cyc0, input int cyc4);
    mx_t m;
    m.we = we; m.addr = addr; m.wdata = wd; m.cycles = cyc0;
    mq0.push_back(m);
    mq4.push_back(cyc4);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(ready0 && ready4) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_wait_expired", {ready0, ready4}, 2'b11);
  endtask

  // lat < 0: no completion event expected from that instance
  task automatic issue(input logic [15:0] ins, input int lat0, input bit er0,
                       input int lat4, input bit er4, input int hold);
    ev_t e;
    wait_idle();
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    if (lat0 >= 0) begin e.is_err = er0; e.at = cyc + lat0; evq0.push_back(e); end
    if (lat4 >= 0) begin e.is_err = er4; e.at = cyc + lat4; evq4.push_back(e); end
    if (hold > 0) begin
      instr = enc(OP_ADD, 3'd5, 3'd1, 3'd1);
      repeat (hold) @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
    wait_idle();
  endtask

  task automatic chk_reg(input logic [2:0] sel, input logic [15:0] exp);
    dbg_sel = sel; #1;
    check($sformatf("R%0d_dut0", sel), dbg0, exp);
    check($sformatf("R%0d_dut4", sel), dbg4, exp);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_ctl0"}, {busy0, done0, err0, req0, we0, opc0}, 0);
    check({tag, "_alu0"}, {a0, b0}, 0);
    check({tag, "_mem0"}, {addr0, wdata0}, 0);
    check({tag, "_ready0"}, ready0, 1);
    check({tag, "_ctl4"}, {busy4, done4, err4, req4, we4, opc4, addr4, wdata4}, 0);
    check({tag, "_ready4"}, ready4, 1);
    for (int s = 0; s < 8; s++) begin
      dbg_sel = 3'(s); #1;
      check($sformatf("%s_dbg%0d", tag, s), {dbg0, dbg4}, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    #12;
    chk_reset("reset");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // LOAD r1,[r0+r0]: mem=0xFFFF, ack on the 3rd request cycle
    rdata_val = 16'hFFFF; ack_delay = 2;
    push_mem(1'b0, 16'h0000, 16'h0000, 3, 3);
    issue(enc(OP_LOAD, 3'd1, 3'd0, 3'd0), 5, 0, 5, 0, 0);
    chk_reg(3'd1, 16'hFFFF);
    // LOAD r2,[r0+r0]: mem=0x0002
    rdata_val = 16'h0002;
    push_mem(1'b0, 16'h0000, 16'h0000, 3, 3);
    issue(enc(OP_LOAD, 3'd2, 3'd0, 3'd0), 5, 0, 5, 0, 0);
    chk_reg(3'd2, 16'h0002);

    // ADD r3,r1,r2 wraps to 0x0001; SUB r4,r2,r1 = 0x0003
    issue(enc(OP_ADD, 3'd3, 3'd1, 3'd2), 2, 0, 2, 0, 0);
    chk_reg(3'd3, 16'h0001);
    issue(enc(OP_SUB, 3'd4, 3'd2, 3'd1), 2, 0, 2, 0, 0);
    chk_reg(3'd4, 16'h0003);

    // STR r2,[r1+r2], ack on 11th request cycle; TIMEOUT=4 instance aborts.
    // instr_valid is held with a junk ADD r5 while busy and must be ignored.
    ack_delay = 10;
    push_mem(1'b1, 16'h0001, 16'h0002, 11, 4);
    issue(enc(OP_STR, 3'd2, 3'd1, 3'd2), 13, 0, 6, 1, 3);
    chk_reg(3'd1, 16'hFFFF);
    chk_reg(3'd2, 16'h0002);
    chk_reg(3'd5, 16'h0000);

    // Illegal opcodes 111 and 010: err pulse, no write
    issue(16'hE000, 2, 1, 2, 1, 0);
    issue(16'h4C90, 2, 1, 2, 1, 0);
    chk_reg(3'd3, 16'h0001);
    chk_reg(3'd4, 16'h0003);
    // ADD r0,r1,r2: done pulses, R0 still 0
    issue(enc(OP_ADD, 3'd0, 3'd1, 3'd2), 2, 0, 2, 0, 0);
    chk_reg(3'd0, 16'h0000);
    // ADD r2,r2,r1: old R2 is used -> 0x0002 + 0xFFFF = 0x0001
    issue(enc(OP_ADD, 3'd2, 3'd2, 3'd1), 2, 0, 2, 0, 0);
    chk_reg(3'd2, 16'h0001);

    // LOAD r3,[r2+r2] with no ack: TIMEOUT=4 instance times out after 4 request
    // cycles; default instance stays in MEM until reset is pulsed.
    ack_delay = -1;
    push_mem(1'b0, 16'h0002, 16'h0000, -1, 4);
    wait_idle();
    instr = enc(OP_LOAD, 3'd3, 3'd2, 3'd2);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    e4.is_err = 1'b1; e4.at = cyc + 6; evq4.push_back(e4);
    begin
      int n = 0;
      while (!ready4 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) check("timeout_wait_expired", ready4, 1);
    end
    @(negedge clk);
    check("req0_held_in_mem", req0, 1);
    dbg_sel = 3'd3; #1;
    check("R3_after_timeout4", dbg4, 16'h0001);

    // Asynchronous reset mid-cycle while in MEM
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("req0_drop_on_reset", req0, 0);
    chk_reset("midreset");
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);

    check("queues_drained", evq0.size() + evq4.size() + mq0.size() + mq4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
